// File: rtl/bram_wavetable_ctrl.sv
// Wavetable playback sequencer for a 256x16 block RAM.
// A phase accumulator stepped at a programmable rate issues table reads.
// A zero-wait host write channel shares the RAM write port.
// When a read and a write hit the same address in one cycle, the write wins
// and the read is retried on the following cycle.
module bram_wavetable_ctrl #(
  parameter int unsigned PHASE_W = 16,
  parameter int unsigned DIV_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic [PHASE_W-1:0] phase_inc,
  input  logic [DIV_W-1:0]   rate_div,
  input  logic               phase_clr,
  input  logic               host_wvalid,
  output logic               host_wready,
  input  logic [7:0]         host_waddr,
  input  logic [15:0]        host_wdata,
  input  logic [15:0]        host_wmask,
  output logic               sample_valid,
  output logic [15:0]        sample_data,
  output logic [7:0]         sample_addr,
  output logic [7:0]         ram_waddr,
  output logic [15:0]        ram_din,
  output logic [15:0]        ram_mask,
  output logic               ram_write_en,
  output logic               ram_wclke,
  output logic [7:0]         ram_raddr,
  output logic               ram_read_en,
  output logic               ram_rclke,
  input  logic [15:0]        ram_dout
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [PHASE_W-1:0] r_phase;
  logic [DIV_W-1:0]   r_div;
  logic               r_pend;
  logic [7:0]         r_pend_addr;
  logic               r_rd_issued;
  logic [7:0]         r_rd_addr;
  logic               r_sample_valid;
  logic [15:0]        r_sample_data;
  logic [7:0]         r_sample_addr;
  logic               r_wready;

  logic               w_wrap;
  logic               w_tick;
  logic [7:0]         w_tick_addr;
  logic               w_wr_acc;
  logic               w_rd_req;
  logic [7:0]         w_rd_addr;
  logic               w_collide;
  logic               w_issue;

  // Tick generation, read request selection and write/read collision detect.
  // A held read takes precedence over a fresh tick, so a tick arriving while a
  // read is pending is dropped while the phase still advances.
  always_comb begin
    w_wrap      = (r_state == S_RUN) && (r_div >= rate_div);
    w_tick      = w_wrap && !phase_clr;
    w_tick_addr = r_phase[PHASE_W-1 -: 8];
    w_wr_acc    = host_wvalid && r_wready;
    w_rd_req    = r_pend || w_tick;
    w_rd_addr   = r_pend ? r_pend_addr : w_tick_addr;
    w_collide   = w_wr_acc && (host_waddr == w_rd_addr);
    w_issue     = w_rd_req && !w_collide;
  end

  // Next-state logic: DRAIN lingers only while a held read is still blocked.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (enable) w_state_nxt = S_RUN;
      S_RUN:   if (!enable) w_state_nxt = S_DRAIN;
      S_DRAIN: if (!(w_rd_req && w_collide)) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Phase/divider, pending read, read pipeline and sample output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_phase        <= '0;
      r_div          <= '0;
      r_pend         <= 1'b0;
      r_pend_addr    <= '0;
      r_rd_issued    <= 1'b0;
      r_rd_addr      <= '0;
      r_sample_valid <= 1'b0;
      r_sample_data  <= '0;
      r_sample_addr  <= '0;
      r_wready       <= 1'b0;
    end else begin
      r_wready <= 1'b1;

      if (phase_clr)   r_phase <= '0;
      else if (w_tick) r_phase <= r_phase + phase_inc;

      if (phase_clr || (r_state != S_RUN) || w_wrap) r_div <= '0;
      else                                           r_div <= r_div + DIV_W'(1);

      r_pend      <= w_rd_req && w_collide;
      r_pend_addr <= w_rd_addr;

      r_rd_issued <= w_issue;
      r_rd_addr   <= w_rd_addr;

      r_sample_valid <= r_rd_issued;
      if (r_rd_issued) begin
        r_sample_data <= ram_dout;
        r_sample_addr <= r_rd_addr;
      end
    end
  end

  assign host_wready  = r_wready;
  assign sample_valid = r_sample_valid;
  assign sample_data  = r_sample_data;
  assign sample_addr  = r_sample_addr;
  assign ram_waddr    = host_waddr;
  assign ram_din      = host_wdata;
  assign ram_mask     = host_wmask;
  assign ram_write_en = w_wr_acc;
  assign ram_wclke    = 1'b1;
  assign ram_raddr    = w_rd_addr;
  assign ram_read_en  = w_issue;
  assign ram_rclke    = 1'b1;

endmodule

// File: tb/tb_bram_wavetable_ctrl.sv
// Scoreboard bench for bram_wavetable_ctrl with a behavioural 256x16 RAM.
module tb_bram_wavetable_ctrl;

  logic        clk = 1'b0;
  logic        rst, enable, phase_clr, host_wvalid;
  logic [15:0] phase_inc;
  logic [7:0]  rate_div;
  logic        host_wready;
  logic [7:0]  host_waddr;
  logic [15:0] host_wdata, host_wmask;
  logic        sample_valid;
  logic [15:0] sample_data;
  logic [7:0]  sample_addr;
  logic [7:0]  ram_waddr, ram_raddr;
  logic [15:0] ram_din, ram_mask, ram_dout;
  logic        ram_write_en, ram_wclke, ram_read_en, ram_rclke;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [7:0]  a;
    logic [15:0] d;
  } samp_t;

  samp_t       exp_q[$];
  samp_t       obs_q[$];
  logic [15:0] sh_mem[256];
  logic [15:0] ram_mem[256];
  logic        tb_load = 1'b0;

  always #5 clk = ~clk;

  bram_wavetable_ctrl #(.PHASE_W(16), .DIV_W(8)) dut (
    .clk(clk), .rst(rst), .enable(enable), .phase_inc(phase_inc),
    .rate_div(rate_div), .phase_clr(phase_clr),
    .host_wvalid(host_wvalid), .host_wready(host_wready),
    .host_waddr(host_waddr), .host_wdata(host_wdata), .host_wmask(host_wmask),
    .sample_valid(sample_valid), .sample_data(sample_data), .sample_addr(sample_addr),
    .ram_waddr(ram_waddr), .ram_din(ram_din), .ram_mask(ram_mask),
    .ram_write_en(ram_write_en), .ram_wclke(ram_wclke),
    .ram_raddr(ram_raddr), .ram_read_en(ram_read_en), .ram_rclke(ram_rclke),
    .ram_dout(ram_dout)
  );

  function automatic logic [15:0] def_word(input logic [7:0] a);
    case (a)
      8'h11:   return 16'h0001;
      8'h40:   return 16'h03E1;
      8'h80:   return 16'h079D;
      8'hC0:   return 16'hFFFE;
      default: return {a, ~a};
    endcase
  endfunction

  // Behavioural SB_RAM256x16: mask bit 1 keeps the old bit.
  always @(posedge clk) begin
    if (tb_load) begin
      for (int unsigned i = 0; i < 256; i++) ram_mem[i] <= def_word(8'(i));
    end else begin
      if (ram_wclke && ram_write_en)
        ram_mem[ram_waddr] <= (ram_mem[ram_waddr] & ram_mask) | (ram_din & ~ram_mask);
      if (ram_rclke && ram_read_en)
        ram_dout <= ram_mem[ram_raddr];
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
    if (sample_valid) obs_q.push_back({sample_addr, sample_data});
  endtask

  task automatic play(input int unsigned k, input int unsigned tail);
    enable = 1'b1;
    repeat (k) step();
    enable = 1'b0;
    repeat (tail) step();
  endtask

  task automatic clr;
    phase_clr = 1'b1;
    step();
    phase_clr = 1'b0;
  endtask

  task automatic push_addr(input logic [7:0] a);
    exp_q.push_back({a, sh_mem[a]});
  endtask

  task automatic test_reset;
    rst = 1'b1; enable = 1'b0; phase_clr = 1'b0; phase_inc = '0; rate_div = '0;
    host_wvalid = 1'b1; host_waddr = 8'h05; host_wdata = 16'hDEAD; host_wmask = '0;
    for (int unsigned i = 0; i < 256; i++) sh_mem[i] = def_word(8'(i));
    tb_load = 1'b1;
    step();
    tb_load = 1'b0;
    step();
    checks++;
    if (sample_valid !== 1'b0 || host_wready !== 1'b0 || ram_write_en !== 1'b0 ||
        ram_read_en !== 1'b0 || ram_wclke !== 1'b1 || ram_rclke !== 1'b1 ||
        sample_data !== 16'h0 || sample_addr !== 8'h0) begin
      errors++;
      $display("FAIL reset_values: got v=%b rdy=%b we=%b re=%b wclke=%b rclke=%b d=%h a=%h, want 0 0 0 0 1 1 0000 00",
               sample_valid, host_wready, ram_write_en, ram_read_en, ram_wclke, ram_rclke,
               sample_data, sample_addr);
    end
    host_wvalid = 1'b0;
    rst = 1'b0;
    step();
    checks++;
    if (host_wready !== 1'b1) begin
      errors++;
      $display("FAIL wready_after_reset: got %b want 1", host_wready);
    end
  endtask

  task automatic test_stream;
    rate_div = 8'd0; phase_inc = 16'h0100;
    for (int unsigned a = 0; a < 196; a++) push_addr(8'(a));
    enable = 1'b1;
    for (int c = 1; c <= 202; c++) begin
      step();
      if (c == 196) enable = 1'b0;
      checks++;
      if (sample_valid !== ((c >= 3 && c <= 198) ? 1'b1 : 1'b0)) begin
        errors++;
        $display("FAIL stream_valid: cycle %0d got %b", c, sample_valid);
      end
      if (sample_valid && (sample_addr == 8'h11 || sample_addr == 8'h80 || sample_addr == 8'hC0)) begin
        checks++;
        if ((sample_addr == 8'h11 && sample_data !== 16'h0001) ||
            (sample_addr == 8'h80 && sample_data !== 16'h079D) ||
            (sample_addr == 8'hC0 && sample_data !== 16'hFFFE)) begin
          errors++;
          $display("FAIL stream_table_word: addr %h got %h", sample_addr, sample_data);
        end
      end
    end
    while (exp_q.size() > 0 || obs_q.size() > 0) begin
      samp_t e, o;
      checks++;
      if (exp_q.size() == 0 || obs_q.size() == 0) begin
        errors++;
        $display("FAIL stream_count: leftover exp=%0d obs=%0d", exp_q.size(), obs_q.size());
        exp_q.delete(); obs_q.delete();
      end else begin
        e = exp_q.pop_front(); o = obs_q.pop_front();
        if (o !== e) begin
          errors++;
          $display("FAIL stream_sample: got a=%h d=%h want a=%h d=%h", o.a, o.d, e.a, e.d);
        end
      end
    end
  endtask

  task automatic test_rate;
    int last;
    int n;
    clr();
    rate_div = 8'd3; phase_inc = 16'h0080;
    push_addr(8'h00); push_addr(8'h00); push_addr(8'h01);
    push_addr(8'h01); push_addr(8'h02); push_addr(8'h02);
    last = -1; n = 0;
    enable = 1'b1;
    for (int c = 1; c <= 32; c++) begin
      step();
      if (c == 24) enable = 1'b0;
      if (sample_valid) begin
        n++;
        checks++;
        if (last < 0 && c != 6) begin
          errors++;
          $display("FAIL rate_first: got cycle %0d want 6", c);
        end else if (last >= 0 && c - last != 4) begin
          errors++;
          $display("FAIL rate_spacing: got %0d want 4", c - last);
        end
        last = c;
      end
    end
    checks++;
    if (n != 6) begin
      errors++;
      $display("FAIL rate_count: got %0d want 6", n);
    end
    while (exp_q.size() > 0 || obs_q.size() > 0) begin
      samp_t e, o;
      checks++;
      if (exp_q.size() == 0 || obs_q.size() == 0) begin
        errors++;
        $display("FAIL rate_count_sb: leftover exp=%0d obs=%0d", exp_q.size(), obs_q.size());
        exp_q.delete(); obs_q.delete();
      end else begin
        e = exp_q.pop_front(); o = obs_q.pop_front();
        if (o !== e) begin
          errors++;
          $display("FAIL rate_sample: got a=%h d=%h want a=%h d=%h", o.a, o.d, e.a, e.d);
        end
      end
    end
    rate_div = 8'd0;
  endtask

  task automatic test_write_mask;
    clr();
    host_wvalid = 1'b1; host_waddr = 8'h40; host_wdata = 16'hA5A5; host_wmask = 16'hFF00;
    #1;
    checks++;
    if (ram_write_en !== 1'b1 || ram_waddr !== 8'h40 || ram_din !== 16'hA5A5 || ram_mask !== 16'hFF00) begin
      errors++;
      $display("FAIL write_port: got we=%b a=%h d=%h m=%h", ram_write_en, ram_waddr, ram_din, ram_mask);
    end
    sh_mem[8'h40] = (sh_mem[8'h40] & 16'hFF00) | (16'hA5A5 & 16'h00FF);
    step();
    host_wvalid = 1'b0;
    #1;
    checks++;
    if (ram_write_en !== 1'b0) begin
      errors++;
      $display("FAIL write_idle: got we=%b want 0", ram_write_en);
    end
    push_addr(8'h00);
    exp_q.push_back({8'h40, 16'h03A5});
    phase_inc = 16'h4000;
    play(2, 6);
    while (exp_q.size() > 0 || obs_q.size() > 0) begin
      samp_t e, o;
      checks++;
      if (exp_q.size() == 0 || obs_q.size() == 0) begin
        errors++;
        $display("FAIL mask_count: leftover exp=%0d obs=%0d", exp_q.size(), obs_q.size());
        exp_q.delete(); obs_q.delete();
      end else begin
        e = exp_q.pop_front(); o = obs_q.pop_front();
        if (o !== e) begin
          errors++;
          $display("FAIL mask_sample: got a=%h d=%h want a=%h d=%h", o.a, o.d, e.a, e.d);
        end
      end
    end
  endtask

  task automatic test_collision;
    clr();
    phase_inc = 16'h2200;
    push_addr(8'h00);
    exp_q.push_back({8'h22, 16'h1234});
    push_addr(8'h66);
    enable = 1'b1;
    step();                       // cycle 1: tick at 0x00
    step();                       // cycle 2: tick at 0x22 with colliding write
    host_wvalid = 1'b1; host_waddr = 8'h22; host_wdata = 16'h1234; host_wmask = 16'h0000;
    sh_mem[8'h22] = 16'h1234;
    #1;
    checks++;
    if (ram_write_en !== 1'b1 || ram_read_en !== 1'b0) begin
      errors++;
      $display("FAIL collide_hold: got we=%b re=%b want 1 0", ram_write_en, ram_read_en);
    end
    step();                       // cycle 3: held read issues, new tick dropped
    host_wvalid = 1'b0;
    #1;
    checks++;
    if (ram_read_en !== 1'b1 || ram_raddr !== 8'h22) begin
      errors++;
      $display("FAIL collide_retry: got re=%b raddr=%h want 1 22", ram_read_en, ram_raddr);
    end
    step();                       // cycle 4
    enable = 1'b0;
    checks++;
    if (sample_valid !== 1'b0) begin
      errors++;
      $display("FAIL collide_gap: got valid=%b want 0", sample_valid);
    end
    step();                       // cycle 5 = tick + 3
    checks++;
    if (sample_valid !== 1'b1 || sample_data !== 16'h1234 || sample_addr !== 8'h22) begin
      errors++;
      $display("FAIL collide_data: got v=%b a=%h d=%h want 1 22 1234", sample_valid, sample_addr, sample_data);
    end
    repeat (6) step();
    while (exp_q.size() > 0 || obs_q.size() > 0) begin
      samp_t e, o;
      checks++;
      if (exp_q.size() == 0 || obs_q.size() == 0) begin
        errors++;
        $display("FAIL collide_count: leftover exp=%0d obs=%0d", exp_q.size(), obs_q.size());
        exp_q.delete(); obs_q.delete();
      end else begin
        e = exp_q.pop_front(); o = obs_q.pop_front();
        if (o !== e) begin
          errors++;
          $display("FAIL collide_sample: got a=%h d=%h want a=%h d=%h", o.a, o.d, e.a, e.d);
        end
      end
    end
  endtask

  task automatic test_wrap;
    clr();
    phase_inc = 16'h0100;
    push_addr(8'h00); push_addr(8'h01); push_addr(8'h00); push_addr(8'hFF); push_addr(8'hFE);
    enable = 1'b1;
    step();                       // cycle 1: addr 0x00, phase -> 0x0100
    step();                       // cycle 2 onward: step backwards
    phase_inc = 16'hFF00;
    step();
    step();
    step();                       // cycle 5: last tick
    enable = 1'b0;
    repeat (6) step();
    while (exp_q.size() > 0 || obs_q.size() > 0) begin
      samp_t e, o;
      checks++;
      if (exp_q.size() == 0 || obs_q.size() == 0) begin
        errors++;
        $display("FAIL wrap_count: leftover exp=%0d obs=%0d", exp_q.size(), obs_q.size());
        exp_q.delete(); obs_q.delete();
      end else begin
        e = exp_q.pop_front(); o = obs_q.pop_front();
        if (o !== e) begin
          errors++;
          $display("FAIL wrap_sample: got a=%h d=%h want a=%h d=%h", o.a, o.d, e.a, e.d);
        end
      end
    end
  endtask

  task automatic test_reset_midflight;
    clr();
    phase_inc = 16'h0100;
    enable = 1'b1;
    repeat (4) step();            // reads in flight from cycles 3 and 4
    rst = 1'b1; enable = 1'b0;
    obs_q.delete();
    step();
    checks++;
    if (sample_valid !== 1'b0 || host_wready !== 1'b0 || ram_read_en !== 1'b0 ||
        ram_write_en !== 1'b0 || sample_data !== 16'h0 || sample_addr !== 8'h0) begin
      errors++;
      $display("FAIL midflight_reset_values: got v=%b rdy=%b re=%b we=%b d=%h a=%h",
               sample_valid, host_wready, ram_read_en, ram_write_en, sample_data, sample_addr);
    end
    rst = 1'b0;
    for (int c = 0; c < 8; c++) begin
      step();
      checks++;
      if (sample_valid !== 1'b0) begin
        errors++;
        $display("FAIL midflight_no_valid: cycle %0d got valid=%b want 0", c, sample_valid);
      end
    end
    obs_q.delete();
    push_addr(8'h00); push_addr(8'h01); push_addr(8'h02);
    play(3, 6);
    while (exp_q.size() > 0 || obs_q.size() > 0) begin
      samp_t e, o;
      checks++;
      if (exp_q.size() == 0 || obs_q.size() == 0) begin
        errors++;
        $display("FAIL restart_count: leftover exp=%0d obs=%0d", exp_q.size(), obs_q.size());
        exp_q.delete(); obs_q.delete();
      end else begin
        e = exp_q.pop_front(); o = obs_q.pop_front();
        if (o !== e) begin
          errors++;
          $display("FAIL restart_sample: got a=%h d=%h want a=%h d=%h", o.a, o.d, e.a, e.d);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_rate();
    test_write_mask();
    test_collision();
    test_wrap();
    test_reset_midflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
